// File: rtl/tx_serializer_p_pkg.sv
// Shared types and helpers for the framed serial transmitter.
// Holds the FSM state encoding, the idle line level and the counter-width helper.
package tx_ser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic LINE_IDLE = 1'b1;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tx_serializer_p_if.sv
// Parallel-in / serial-out bundle between the data source and the transmitter.
// master = data source side, slave = transmitter side.
interface tx_serializer_p_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] Pin;
   logic              send;
   logic              Sout;
   logic              busy;
   logic              done;
   logic              err;

   modport master (output Pin, send, input Sout, busy, done, err);
   modport slave  (input Pin, send, output Sout, busy, done, err);
endinterface

// File: rtl/tx_serializer_p_bit_timer.sv
// Bit-time divider: counts CLKS_PER_BIT clocks while enabled, strobes bit_end on the last one.
// Zero latency strobe; clear restarts the count so a new frame begins on a full bit.
module tx_bit_timer
   import tx_ser_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic bit_end
);

   localparam int CW = cnt_w(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] clk_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         clk_cnt <= '0;
      end else if (en) begin
         clk_cnt <= (clk_cnt == LAST) ? '0 : clk_cnt + 1'b1;
      end
   end

   assign bit_end = en && (clk_cnt == LAST);

endmodule

// File: rtl/tx_serializer_p.sv
// Framed serializer: start, DATA_W data bits, optional parity (TX_PARITY_EN), stop bits.
// Sout registered, first start-bit clock follows the accepting edge; requests while busy only raise err.
module tx_serializer_p
   import tx_ser_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1,
   parameter int LSB_FIRST    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic CLOCK_50,
   input  logic reset,
   tx_serializer_p_if.slave bus
);

   localparam int BW = $clog2(DATA_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_e         state, state_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [BW-1:0]     bit_cnt, bit_cnt_n;
   logic              stop_cnt, stop_cnt_n;
   logic              accept, bit_end, line_n, send_d, par_q, frame_end, busy;

   tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk     (CLOCK_50),
      .reset   (reset),
      .clear   (accept),
      .en      (busy),
      .bit_end (bit_end)
   );

`ifdef TX_PARITY_EN
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         par_q <= 1'b0;
      end else if (accept) begin
         par_q <= (^bus.Pin) ^ 1'(PARITY_ODD);
      end
   end
`else
   assign par_q = 1'(PARITY_ODD);
`endif

   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      bit_cnt_n  = bit_cnt;
      stop_cnt_n = stop_cnt;
      accept     = 1'b0;
      line_n     = LINE_IDLE;
      case (state)
         IDLE: begin
            if (bus.send) begin
               accept     = 1'b1;
               state_n    = START;
               shreg_n    = bus.Pin;
               bit_cnt_n  = '0;
               stop_cnt_n = 1'b0;
            end
         end
         START: if (bit_end) state_n = DATA;
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == LAST_BIT) begin
`ifdef TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_cnt_n = bit_cnt + 1'b1;
                  if (LSB_FIRST != 0) shreg_n = {1'b0, shreg[DATA_W-1:1]};
                  else                shreg_n = {shreg[DATA_W-2:0], 1'b0};
               end
            end
         end
         PARITY: if (bit_end) state_n = STOP;
         STOP: begin
            if (bit_end) begin
               if (stop_cnt == LAST_STOP) state_n = IDLE;
               else                       stop_cnt_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Sout is registered, so drive it from the state being entered.
      case (state_n)
         START:   line_n = 1'b0;
         DATA:    line_n = (LSB_FIRST != 0) ? shreg_n[0] : shreg_n[DATA_W-1];
         PARITY:  line_n = par_q;
         default: line_n = LINE_IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign frame_end = (state == STOP) && bit_end && (stop_cnt == LAST_STOP);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         send_d   <= 1'b0;
         bus.Sout <= LINE_IDLE;
         bus.err  <= 1'b0;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bit_cnt  <= bit_cnt_n;
         stop_cnt <= stop_cnt_n;
         send_d   <= bus.send;
         bus.Sout <= line_n;
         // A rise landing on the frame's last clock is treated as a fresh request.
         bus.err  <= bus.send && !send_d && busy && !frame_end;
      end
   end

   assign bus.busy = busy;
   assign bus.done = frame_end;

endmodule

// File: doc/tx_serializer_p.md
Name: tx_serializer_p

Overview:
Parametrised next-generation SERDES transmitter. Captures a DATA_W-bit parallel word on a send request and shifts it out on Sout as a framed serial stream: start bit, data, optional parity, then stop bits. Each bit is held for CLKS_PER_BIT clocks. Flags requests that arrive while a frame is in flight; sits between the parallel data source and the serial line driver.

Parameters:
DATA_W, 8, payload width in bits (>=2)
CLKS_PER_BIT, 4, clocks per serial bit (>=1)
STOP_BITS, 1, number of stop bits (1 or 2)
LSB_FIRST, 1, 1 = Pin[0] sent first, 0 = Pin[DATA_W-1] sent first
PARITY_ODD, 0, parity sense when TX_PARITY_EN is defined (0 = even, 1 = odd)

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Pin  in  DATA_W  parallel payload, sampled only on an accepted send
send  in  1  level request; accepted in any IDLE cycle where it is high
Sout  out  1  serial line, registered; idles high
busy  out  1  high while a frame is being transmitted
done  out  1  one-cycle pulse in the final clock of the last stop bit
err  out  1  one-cycle pulse on a rising edge of send while busy

Behaviour:
- Reset, on any clock edge with reset=1: state IDLE; Sout=1, busy=0, done=0, err=0; send_d=0; counters cleared. Reset mid-frame drops the frame: Sout=1 on the next cycle, no done pulse.
- States and transitions: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: Sout=1, busy=0. If send=1 at edge k, capture Pin into the shift register and enter START.
- START: from cycle k+1, Sout=0 and busy=1, held for CLKS_PER_BIT cycles.
- DATA: DATA_W bits, each held CLKS_PER_BIT cycles; order set by LSB_FIRST.
- PARITY (only with TX_PARITY_EN): one bit-time carrying the parity bit.
- STOP: Sout=1 for STOP_BITS*CLKS_PER_BIT cycles. done=1 in the last of those cycles. Then IDLE.
- Pin changes after capture have no effect on the current frame.
- Frame length F = (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P = 1 with parity, else 0.
- Back-to-back: if send is still high, the next capture occurs in the single IDLE cycle after STOP. Frames are therefore separated by exactly one idle clock with Sout=1.
- Counters: clk_cnt is $clog2(CLKS_PER_BIT) bits (minimum 1), counts 0..CLKS_PER_BIT-1, then wraps. A bit advances when clk_cnt = CLKS_PER_BIT-1. With CLKS_PER_BIT=1, a bit advances every cycle.
- bit_cnt is $clog2(DATA_W) bits, counts 0..DATA_W-1; DATA exits when bit_cnt = DATA_W-1 at bit end. A separate stop counter handles STOP_BITS=2.
- err: send_d registers send each cycle. err = send & ~send_d & busy, registered. The request is not queued; the running frame is unaffected.
- A send rising edge in the same cycle the FSM returns to IDLE is not an error.
- err while in IDLE is never asserted.

Optional Feature:
TX_PARITY_EN defined:
- Parity state is present and the frame gains one bit-time.
- Parity = XOR of the captured word, XOR PARITY_ODD.
TX_PARITY_EN undefined:
- No parity state; DATA goes directly to STOP.
- PARITY_ODD is ignored.

Decomposition:
- Package tx_ser_pkg: state enum typedef (IDLE, START, DATA, PARITY, STOP); constant LINE_IDLE=1'b1; function for clk_cnt width with a minimum of 1.
- One sub-module, tx_bit_timer: counts CLKS_PER_BIT and emits a bit_end strobe. It is cleared when the FSM enters START and on reset.

Test Plan:
1. Defaults, no parity, Pin=8'hA5, send pulsed 1 cycle at edge k -> Sout=0 for k+1..k+4, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1. done at cycle k+40; busy high k+1..k+40.
2. TX_PARITY_EN, PARITY_ODD=0, Pin=8'hA5 (4 ones) -> parity bit 0, done at k+44. With Pin=8'h07 -> parity bit 1.
3. send held high for 100 cycles, Pin=8'h3C -> frames start at k and k+41, one idle-high cycle between them, two done pulses. err stays 0.
4. Mid-frame send 0->1 at cycle k+10 -> err pulses exactly once, at k+11. The frame completes unchanged; no second frame starts unless send is high in IDLE.
5. reset asserted at k+15 mid-DATA -> Sout=1, busy=0 the next cycle; no done pulse. A new send after reset gives a clean frame.
6. LSB_FIRST=0, CLKS_PER_BIT=1, STOP_BITS=2, Pin=8'h81 -> Sout sequence 0,1,0,0,0,0,0,0,1,1,1 on consecutive cycles, then done.
